btb_nway_plru: RTL and testbench
================================

// Module: btb_nway_plru
// PURPOSE
//   Parametrised N-way set-associative branch target buffer with tree pseudo-LRU
//   replacement; generalises the fixed direct-mapped BTB (btb_s_index sets).
//   Sits in IF: looked up with fetch PC, result registered into IF/ID alongside
//   btb_read_hit/btb_out; written from EX when a br/jal/jalr resolves; flushed
//   on fence/context events. Entry payload = btb_entry (target_address, btb_ops).
// PARAMETERS
//   S_INDEX  4   log2(number of sets); sets = 2**S_INDEX
//   WAYS     4   associativity; power of two, 2..8; PLRU tree = WAYS-1 bits/set
//   (derived) TAG_W = 30 - S_INDEX; index = pc[S_INDEX+1:2], tag = pc[31:S_INDEX+2]
// PORTS
//   clk          in   1   clock
//   rst          in   1   reset, synchronous, active-low
//   rd_en        in   1   perform lookup this cycle (low = IF stalled)
//   rd_pc        in   32  fetch PC to look up; pc[1:0] ignored
//   rd_hit       out  1   registered: lookup hit
//   rd_entry     out  34  registered: btb_entry {target_address, br_jal_jalr}
//   upd_valid    in   1   write/invalidate request from EX
//   upd_inv      in   1   1 = invalidate matching entry, 0 = install/overwrite
//   upd_pc       in   32  PC of resolved control-transfer instruction
//   upd_entry    in   34  btb_entry to install (ignored when upd_inv=1)
//   flush        in   1   invalidate every entry this cycle
// BEHAVIOUR
//   Reset (rst==0 at clk edge): all valid bits 0, all PLRU bits 0, rd_hit=0,
//     rd_entry=0 (target 0, type br). Target/tag storage need not be reset.
//   Lookup: 1-cycle latency. rd_en=1 at edge t -> rd_hit/rd_entry valid after t.
//     rd_en=0 -> rd_hit/rd_entry hold previous values (stall-safe).
//   Hit = valid && tag match in indexed set. Multiple matches cannot arise; if
//     present, lowest-numbered way wins. Miss -> rd_hit=0, rd_entry=0.
//   Read-before-write: lookup in the same cycle as an update to the same set
//     returns pre-update contents; new entry visible from the next lookup.
//   PLRU: tree bits per set; "touch(w)" points tree away from way w.
//     Read hit (rd_en=1) touches hit way. Install touches written way.
//     Invalidate and misses do not touch. Read touch and update touch same set
//     same cycle: read touch applied first, update touch second (update way MRU).
//   Install (upd_valid=1, upd_inv=0): if tag hits in set -> overwrite that way;
//     else lowest-numbered invalid way; else PLRU victim. Sets valid, tag, entry.
//   Invalidate (upd_valid=1, upd_inv=1): clear valid of matching way; miss = no-op.
//   Flush: clears all valid bits and PLRU bits at the edge; overrides any update
//     that cycle; a lookup in the flush cycle registers rd_hit=0.
//   Reset mid-operation overrides flush, update and lookup.
//   No handshake backpressure: updates always accepted in one cycle.
// TESTING
//   T1 reset: rst=0 2 cycles -> rd_hit=0, rd_entry=0; lookup any PC -> miss.
//   T2 install/hit: upd pc=0x0000_1040 entry{0x0000_2000,jal}; next cycle rd_pc=
//      0x0000_1040 -> 1 cycle later rd_hit=1, target=0x0000_2000, type=jal.
//   T3 fill+evict (S_INDEX=4,WAYS=4): install PCs 0x040,0x440,0x840,0xC40 (set 0);
//      read-hit 0x040,0x440,0x840; install 0x1040 -> 0xC40 evicted, others hit.
//   T4 overwrite/inv: reinstall 0x040 target 0x3000 -> hit returns 0x3000, no
//      eviction of other ways; upd_inv pc=0x040 -> lookup 0x040 misses.
//   T5 same-cycle: lookup and install same set/PC -> first read miss, next hit;
//      flush with concurrent install -> all subsequent lookups miss.
//   T6 stall/reset: rd_en=0 for 3 cycles -> outputs held; assert rst with valid
//      entries -> all lookups miss afterwards.

Source files
------------

// File: rtl/btb_nway_plru.sv
// N-way set-associative branch target buffer with tree pseudo-LRU replacement.
// Lookup results are registered (1-cycle latency); updates are single-cycle writes.
module btb_nway_plru #(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic [33:0] rd_entry,
  input  logic        upd_valid,
  input  logic        upd_inv,
  input  logic [31:0] upd_pc,
  input  logic [33:0] upd_entry,
  input  logic        flush
);

  localparam int SETS    = 2 ** S_INDEX;
  localparam int TAG_W   = 30 - S_INDEX;
  localparam int WAY_W   = $clog2(WAYS);
  localparam int PLRU_W  = WAYS - 1;
  localparam int ENTRY_W = 34;

  // Tree nodes are heap-numbered 1..WAYS-1; a node bit of 1 means the victim
  // lies in the right subtree, 0 means the left subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [2*WAYS-1:0] tree;
    logic [WAY_W:0]    node;
    tree            = '0;
    tree[WAYS-1:1]  = bits;
    node            = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++) begin
      node = {node[WAY_W-1:0], tree[node]};
    end
    return node[WAY_W-1:0];
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [2*WAYS-1:0] tree;
    logic [WAY_W:0]    node;
    logic [WAY_W-1:0]  path;
    logic              b;
    tree           = '0;
    tree[WAYS-1:1] = bits;
    node           = (WAY_W+1)'(1);
    path           = way;
    for (int l = 0; l < WAY_W; l++) begin
      b          = path[WAY_W-1];
      tree[node] = ~b;
      node       = {node[WAY_W-1:0], b};
      path       = path << 1;
    end
    return tree[WAYS-1:1];
  endfunction

  logic [WAYS-1:0]    valid_q [SETS];
  logic [PLRU_W-1:0]  plru_q  [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [ENTRY_W-1:0] entry_q [SETS][WAYS];

  logic [S_INDEX-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0]   rd_tag, upd_tag;

  assign rd_idx  = rd_pc[S_INDEX+1:2];
  assign rd_tag  = rd_pc[31:S_INDEX+2];
  assign upd_idx = upd_pc[S_INDEX+1:2];
  assign upd_tag = upd_pc[31:S_INDEX+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[1:0], upd_pc[1:0]};

  logic             rd_hit_c;
  logic [WAY_W-1:0] rd_way;
  logic             upd_hit_c;
  logic [WAY_W-1:0] upd_hit_way;
  logic             upd_free_c;
  logic [WAY_W-1:0] upd_free_way;

  // Descending scans so the lowest-numbered matching/free way wins.
  always_comb begin
    rd_hit_c     = 1'b0;
    rd_way       = '0;
    upd_hit_c    = 1'b0;
    upd_hit_way  = '0;
    upd_free_c   = 1'b0;
    upd_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
        rd_hit_c = 1'b1;
        rd_way   = WAY_W'(w);
      end
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit_c   = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!valid_q[upd_idx][w]) begin
        upd_free_c   = 1'b1;
        upd_free_way = WAY_W'(w);
      end
    end
  end

  logic              rd_touch;
  logic              upd_install;
  logic              upd_kill;
  logic [PLRU_W-1:0] plru_rd_new;
  logic [PLRU_W-1:0] upd_base;
  logic [PLRU_W-1:0] plru_upd_new;
  logic [WAY_W-1:0]  upd_way;

  assign rd_touch    = rd_en && rd_hit_c;
  assign upd_install = upd_valid && !upd_inv;
  assign upd_kill    = upd_valid && upd_inv && upd_hit_c;
  assign plru_rd_new = plru_touch(plru_q[rd_idx], rd_way);

  // A same-set read hit is folded in first so the installed way ends up MRU.
  assign upd_base     = (rd_touch && (rd_idx == upd_idx)) ? plru_rd_new : plru_q[upd_idx];
  assign upd_way      = upd_hit_c  ? upd_hit_way  :
                        upd_free_c ? upd_free_way : plru_victim(upd_base);
  assign plru_upd_new = plru_touch(upd_base, upd_way);

  // Control state: valid and replacement bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (rd_touch) begin
        plru_q[rd_idx] <= plru_rd_new;
      end
      if (upd_install) begin
        valid_q[upd_idx][upd_way] <= 1'b1;
        plru_q[upd_idx]           <= plru_upd_new;
      end else if (upd_kill) begin
        valid_q[upd_idx][upd_way] <= 1'b0;
      end
    end
  end

  // Tag and payload storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (rst && !flush && upd_install) begin
      tag_q[upd_idx][upd_way]   <= upd_tag;
      entry_q[upd_idx][upd_way] <= upd_entry;
    end
  end

  // Stage p0 -> IF/ID: registered lookup result, held while rd_en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_hit   <= 1'b0;
      rd_entry <= '0;
    end else if (rd_en) begin
      rd_hit   <= rd_hit_c && !flush;
      rd_entry <= (rd_hit_c && !flush) ? entry_q[rd_idx][rd_way] : '0;
    end
  end

endmodule

// File: tb/tb_btb_nway_plru.sv
// Directed table-driven bench for btb_nway_plru (S_INDEX=4, WAYS=4).
module tb_btb_nway_plru;

  localparam logic [1:0] BR   = 2'd0;
  localparam logic [1:0] JAL  = 2'd1;
  localparam logic [1:0] JALR = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [31:0] rd_pc;
  logic        rd_hit;
  logic [33:0] rd_entry;
  logic        upd_valid;
  logic        upd_inv;
  logic [31:0] upd_pc;
  logic [33:0] upd_entry;
  logic        flush;

  always #5 clk = ~clk;

  btb_nway_plru #(.S_INDEX(4), .WAYS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_pc     (rd_pc),
    .rd_hit    (rd_hit),
    .rd_entry  (rd_entry),
    .upd_valid (upd_valid),
    .upd_inv   (upd_inv),
    .upd_pc    (upd_pc),
    .upd_entry (upd_entry),
    .flush     (flush)
  );

  typedef struct {
    logic        rd_en;
    logic [31:0] rd_pc;
    logic        upd_valid;
    logic        upd_inv;
    logic [31:0] upd_pc;
    logic [33:0] upd_entry;
    logic        flush;
    logic        exp_hit;
    logic [33:0] exp_entry;
  } vec_t;

  vec_t vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic logic [33:0] ent(input logic [31:0] t, input logic [1:0] ty);
    return {t, ty};
  endfunction

  function automatic vec_t v(input logic re, input logic [31:0] rpc,
                             input logic uv, input logic ui, input logic [31:0] upc,
                             input logic [33:0] ue, input logic fl,
                             input logic eh, input logic [33:0] ee);
    vec_t r;
    r.rd_en = re;  r.rd_pc = rpc; r.upd_valid = uv; r.upd_inv = ui;
    r.upd_pc = upc; r.upd_entry = ue; r.flush = fl;
    r.exp_hit = eh; r.exp_entry = ee;
    return r;
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_upd();
    upd_valid = 1'b0; upd_inv = 1'b0; upd_pc = '0; upd_entry = '0; flush = 1'b0;
  endtask

  initial begin
    logic [31:0] pcs [4];

    // Same-set lookup/install, flush with concurrent install.
    vecs.push_back(v(1, 32'h1040, 1, 0, 32'h1040, ent(32'h2000, JAL), 0, 0, '0));
    vecs.push_back(v(1, 32'h1040, 0, 0, 0, '0, 0, 1, ent(32'h2000, JAL)));
    vecs.push_back(v(1, 32'h1040, 1, 0, 32'h2080, ent(32'h5000, BR), 1, 0, '0));
    vecs.push_back(v(1, 32'h2080, 0, 0, 0, '0, 0, 0, '0));
    vecs.push_back(v(1, 32'h1040, 0, 0, 0, '0, 0, 0, '0));
    // Fill set 0; reads of set 1 miss meanwhile.
    vecs.push_back(v(1, 32'h0004, 1, 0, 32'h0040, ent(32'h0100, BR),   0, 0, '0));
    vecs.push_back(v(1, 32'h0004, 1, 0, 32'h0440, ent(32'h0200, JAL),  0, 0, '0));
    vecs.push_back(v(1, 32'h0004, 1, 0, 32'h0840, ent(32'h0300, JALR), 0, 0, '0));
    vecs.push_back(v(1, 32'h0004, 1, 0, 32'h0C40, ent(32'h0400, BR),   0, 0, '0));
    // Hit order 2,0,1 leaves the tree pointing at way 3 (0xC40).
    vecs.push_back(v(1, 32'h0840, 0, 0, 0, '0, 0, 1, ent(32'h0300, JALR)));
    vecs.push_back(v(1, 32'h0040, 0, 0, 0, '0, 0, 1, ent(32'h0100, BR)));
    vecs.push_back(v(1, 32'h0440, 0, 0, 0, '0, 0, 1, ent(32'h0200, JAL)));
    vecs.push_back(v(1, 32'h0004, 1, 0, 32'h1040, ent(32'h0500, JAL), 0, 0, '0));
    vecs.push_back(v(1, 32'h0C40, 0, 0, 0, '0, 0, 0, '0));
    vecs.push_back(v(1, 32'h1040, 0, 0, 0, '0, 0, 1, ent(32'h0500, JAL)));
    vecs.push_back(v(1, 32'h0040, 0, 0, 0, '0, 0, 1, ent(32'h0100, BR)));
    vecs.push_back(v(1, 32'h0440, 0, 0, 0, '0, 0, 1, ent(32'h0200, JAL)));
    vecs.push_back(v(1, 32'h0840, 0, 0, 0, '0, 0, 1, ent(32'h0300, JALR)));
    // Overwrite existing tag, then invalidate.
    vecs.push_back(v(1, 32'h0004, 1, 0, 32'h0040, ent(32'h3000, BR), 0, 0, '0));
    vecs.push_back(v(1, 32'h0040, 0, 0, 0, '0, 0, 1, ent(32'h3000, BR)));
    vecs.push_back(v(1, 32'h0440, 0, 0, 0, '0, 0, 1, ent(32'h0200, JAL)));
    vecs.push_back(v(1, 32'h0840, 0, 0, 0, '0, 0, 1, ent(32'h0300, JALR)));
    vecs.push_back(v(1, 32'h1040, 0, 0, 0, '0, 0, 1, ent(32'h0500, JAL)));
    vecs.push_back(v(1, 32'h0040, 1, 1, 32'h0040, '0, 0, 1, ent(32'h3000, BR)));
    vecs.push_back(v(1, 32'h0040, 0, 0, 0, '0, 0, 0, '0));
    vecs.push_back(v(1, 32'h0440, 1, 1, 32'h0C40, '0, 0, 1, ent(32'h0200, JAL)));
    vecs.push_back(v(1, 32'h0440, 0, 0, 0, '0, 0, 1, ent(32'h0200, JAL)));
    // Stall: outputs hold even while an install happens.
    vecs.push_back(v(0, 32'h0840, 0, 0, 0, '0, 0, 1, ent(32'h0200, JAL)));
    vecs.push_back(v(0, 32'h0004, 1, 0, 32'h0004, ent(32'h0600, JALR), 0, 1, ent(32'h0200, JAL)));
    vecs.push_back(v(0, 32'h0004, 0, 0, 0, '0, 0, 1, ent(32'h0200, JAL)));
    vecs.push_back(v(1, 32'h0004, 0, 0, 0, '0, 0, 1, ent(32'h0600, JALR)));
    // Freed way 0 is refilled before any PLRU eviction.
    vecs.push_back(v(1, 32'h0004, 1, 0, 32'h0C40, ent(32'h0700, BR), 0, 1, ent(32'h0600, JALR)));
    vecs.push_back(v(1, 32'h0C40, 0, 0, 0, '0, 0, 1, ent(32'h0700, BR)));
    vecs.push_back(v(1, 32'h1040, 0, 0, 0, '0, 0, 1, ent(32'h0500, JAL)));
    vecs.push_back(v(1, 32'h0840, 0, 0, 0, '0, 0, 1, ent(32'h0300, JALR)));
    vecs.push_back(v(1, 32'h0440, 0, 0, 0, '0, 0, 1, ent(32'h0200, JAL)));

    rst = 1'b0; rd_en = 1'b1; rd_pc = 32'h1040;
    idle_upd();
    step();
    step();
    check("reset rd_hit", {33'd0, rd_hit}, 34'd0);
    check("reset rd_entry", rd_entry, 34'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rd_en     = vecs[i].rd_en;
      rd_pc     = vecs[i].rd_pc;
      upd_valid = vecs[i].upd_valid;
      upd_inv   = vecs[i].upd_inv;
      upd_pc    = vecs[i].upd_pc;
      upd_entry = vecs[i].upd_entry;
      flush     = vecs[i].flush;
      step();
      check($sformatf("vec%0d rd_hit", i), {33'd0, rd_hit}, {33'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d rd_entry", i), rd_entry, vecs[i].exp_entry);
    end
    idle_upd();

    // Reset in the middle of traffic wins over lookup and install.
    rd_en = 1'b1; rd_pc = 32'h0C40;
    upd_valid = 1'b1; upd_pc = 32'h0080; upd_entry = ent(32'h0900, JAL);
    rst = 1'b0;
    step();
    check("midreset rd_hit", {33'd0, rd_hit}, 34'd0);
    check("midreset rd_entry", rd_entry, 34'd0);
    rst = 1'b1;
    idle_upd();
    pcs = '{32'h0C40, 32'h0840, 32'h0004, 32'h0080};
    for (int i = 0; i < 4; i++) begin
      rd_pc = pcs[i];
      step();
      check($sformatf("postreset%0d rd_hit", i), {33'd0, rd_hit}, 34'd0);
      check($sformatf("postreset%0d rd_entry", i), rd_entry, 34'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
